// File: rtl/sha2_ctrl_fsm.sv
// Sequencing controller for a SHA-2 core: message-word load, round stepping, H update, digest handshake.
// Optional abort input enabled by defining SHA2_CTRL_ABORT_EN.
module sha2_ctrl_fsm #(
   parameter int ROUNDS    = 64,
   parameter int MSG_WORDS = 16,
   parameter int RIDX_W    = $clog2(ROUNDS)
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef SHA2_CTRL_ABORT_EN
   input  logic              abort_i,
`endif
   input  logic              start_i,
   input  logic              msg_valid_i,
   output logic              msg_ready_o,
   input  logic              blk_last_i,
   output logic              msg_ld_o,
   output logic [3:0]        word_idx_o,
   output logic              iv_ld_o,
   output logic              wv_ld_o,
   output logic              hash_en_o,
   output logic [RIDX_W-1:0] round_o,
   output logic              final_o,
   output logic              digest_valid_o,
   input  logic              digest_ready_i,
   output logic              busy_o,
   output logic [15:0]       blk_cnt_o
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] ROUND = 3'd2;
   localparam logic [2:0] FINAL = 3'd3;
   localparam logic [2:0] OUT   = 3'd4;

   localparam logic [3:0]        LAST_WORD  = 4'(MSG_WORDS - 1);
   localparam logic [RIDX_W-1:0] LAST_ROUND = RIDX_W'(ROUNDS - 1);

   logic [2:0]        state;
   logic [3:0]        word_idx;
   logic [RIDX_W-1:0] round_cnt;
   logic [15:0]       blk_cnt;
   logic              first_blk;
   logic              last_blk;
   logic              abort;

`ifdef SHA2_CTRL_ABORT_EN
   assign abort = abort_i;
`else
   assign abort = 1'b0;
`endif

   assign msg_ready_o    = (state == LOAD);
   assign msg_ld_o       = msg_valid_i & msg_ready_o;
   assign wv_ld_o        = msg_ld_o & (word_idx == 4'd0);
   assign iv_ld_o        = wv_ld_o & first_blk;
   assign hash_en_o      = (state == ROUND);
   // Abort masks the H update and the digest in the cycle it is raised
   assign final_o        = (state == FINAL) & ~abort;
   assign digest_valid_o = (state == OUT) & ~abort;
   assign busy_o         = (state != IDLE);
   assign word_idx_o     = word_idx;
   assign round_o        = round_cnt;
   assign blk_cnt_o      = blk_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || abort) begin
         state     <= IDLE;
         word_idx  <= 4'd0;
         round_cnt <= '0;
         blk_cnt   <= 16'd0;
         first_blk <= 1'b0;
         last_blk  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  state     <= LOAD;
                  word_idx  <= 4'd0;
                  blk_cnt   <= 16'd0;
                  first_blk <= 1'b1;
               end
            end
            LOAD: begin
               if (msg_valid_i) begin
                  if (word_idx == 4'd0) begin
                     first_blk <= 1'b0;
                  end
                  // last_blk is only meaningful on the final word of a block
                  if (word_idx == LAST_WORD) begin
                     last_blk <= blk_last_i;
                     word_idx <= 4'd0;
                     state    <= ROUND;
                  end else begin
                     word_idx <= word_idx + 4'd1;
                  end
               end
            end
            ROUND: begin
               if (round_cnt == LAST_ROUND) begin
                  round_cnt <= '0;
                  state     <= FINAL;
               end else begin
                  round_cnt <= round_cnt + RIDX_W'(1);
               end
            end
            FINAL: begin
               if (blk_cnt != 16'hFFFF) begin
                  blk_cnt <= blk_cnt + 16'd1;
               end
               state <= last_blk ? OUT : LOAD;
            end
            OUT: begin
               if (digest_ready_i) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sha2_ctrl_fsm.sv
// Testbench for sha2_ctrl_fsm: builds an expected per-cycle timeline from the message structure and replays it.
// Abort scenarios are compiled in when SHA2_CTRL_ABORT_EN is defined.
module tb_sha2_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_i = 1'b0;
   logic        msg_valid_i = 1'b0;
   logic        blk_last_i = 1'b0;
   logic        digest_ready_i = 1'b0;
`ifdef SHA2_CTRL_ABORT_EN
   logic        abort_i = 1'b0;
`endif

   logic        msg_ready_o, msg_ld_o, iv_ld_o, wv_ld_o, hash_en_o, final_o, digest_valid_o, busy_o;
   logic [3:0]  word_idx_o;
   logic [5:0]  round_o;
   logic [15:0] blk_cnt_o;

   logic        rdy80, ld80, iv80, wv80, hen80, fin80, dv80, busy80;
   logic [3:0]  widx80;
   logic [6:0]  round80;
   logic [15:0] blk80;

   int tests_run = 0;
   int tests_failed = 0;
   int fail_prints = 0;
   int blk_model = 0;
   int n_iv, n_wv, n_fin, n_ld, n_hen, n_dv, first_fin, first_dv;
   logic [15:0] last_blk_seen;

   typedef struct {
      logic        start;
      logic        valid;
      logic        last;
      logic        dready;
      logic [35:0] exp;
   } cyc_t;
   cyc_t tl[$];

   logic [35:0] act;
   assign act = {msg_ready_o, msg_ld_o, word_idx_o, iv_ld_o, wv_ld_o, hash_en_o, 2'b00, round_o,
                 final_o, digest_valid_o, busy_o, blk_cnt_o};

   always #5 clk = ~clk;

   sha2_ctrl_fsm dut (
      .clk(clk), .rst_n(rst_n),
`ifdef SHA2_CTRL_ABORT_EN
      .abort_i(abort_i),
`endif
      .start_i(start_i), .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o),
      .blk_last_i(blk_last_i), .msg_ld_o(msg_ld_o), .word_idx_o(word_idx_o),
      .iv_ld_o(iv_ld_o), .wv_ld_o(wv_ld_o), .hash_en_o(hash_en_o), .round_o(round_o),
      .final_o(final_o), .digest_valid_o(digest_valid_o), .digest_ready_i(digest_ready_i),
      .busy_o(busy_o), .blk_cnt_o(blk_cnt_o)
   );

   sha2_ctrl_fsm #(.ROUNDS(80)) dut80 (
      .clk(clk), .rst_n(rst_n),
`ifdef SHA2_CTRL_ABORT_EN
      .abort_i(abort_i),
`endif
      .start_i(start_i), .msg_valid_i(msg_valid_i), .msg_ready_o(rdy80),
      .blk_last_i(blk_last_i), .msg_ld_o(ld80), .word_idx_o(widx80),
      .iv_ld_o(iv80), .wv_ld_o(wv80), .hash_en_o(hen80), .round_o(round80),
      .final_o(fin80), .digest_valid_o(dv80), .digest_ready_i(digest_ready_i),
      .busy_o(busy80), .blk_cnt_o(blk80)
   );

   function automatic logic rb();
      return 1'($urandom_range(1));
   endfunction

   function automatic logic [35:0] pk(input logic rdy, input logic ld, input int widx, input logic iv,
                                      input logic wv, input logic hen, input int rnd, input logic fin,
                                      input logic dv, input logic bsy, input int blk);
      return {rdy, ld, 4'(widx), iv, wv, hen, 8'(rnd), fin, dv, bsy, 16'(blk)};
   endfunction

   function automatic void push_cyc(input logic s, input logic v, input logic l, input logic d,
                                    input logic [35:0] e);
      cyc_t c;
      c.start = s; c.valid = v; c.last = l; c.dready = d; c.exp = e;
      tl.push_back(c);
   endfunction

   // Expected timeline: start cycle, per block (words with gaps, ROUNDS steps, one H update), then OUT wait
   task automatic build_message(input int nb, input int gmax, input int owait, input bit start_in_out,
                                input int idle_post);
      tl.delete();
      push_cyc(1'b1, rb(), rb(), rb(), pk(0,0,0,0,0,0,0,0,0,0,blk_model));
      blk_model = 0;
      for (int b = 0; b < nb; b++) begin
         for (int w = 0; w < 16; w++) begin
            int g = $urandom_range(gmax, 0);
            for (int k = 0; k < g; k++)
               push_cyc(rb(), 1'b0, rb(), rb(), pk(1,0,w,0,0,0,0,0,0,1,blk_model));
            push_cyc(rb(), 1'b1, (w == 15) ? (b == nb - 1) : rb(), rb(),
                     pk(1,1,w,(w == 0 && b == 0),(w == 0),0,0,0,0,1,blk_model));
         end
         for (int r = 0; r < 64; r++)
            push_cyc(rb(), rb(), rb(), rb(), pk(0,0,0,0,0,1,r,0,0,1,blk_model));
         push_cyc(rb(), rb(), rb(), rb(), pk(0,0,0,0,0,0,0,1,0,1,blk_model));
         if (blk_model < 65535) blk_model++;
      end
      for (int k = 0; k < owait; k++)
         push_cyc(start_in_out ? 1'b1 : rb(), rb(), rb(), 1'b0, pk(0,0,0,0,0,0,0,0,1,1,blk_model));
      push_cyc(start_in_out ? 1'b1 : rb(), rb(), rb(), 1'b1, pk(0,0,0,0,0,0,0,0,1,1,blk_model));
      for (int k = 0; k < idle_post; k++)
         push_cyc(1'b0, rb(), rb(), rb(), pk(0,0,0,0,0,0,0,0,0,0,blk_model));
   endtask

   task automatic replay(input string name, input int rst_at, input int abort_at);
      logic [35:0] e;
      bit cut = 0;
      n_iv = 0; n_wv = 0; n_fin = 0; n_ld = 0; n_hen = 0; n_dv = 0; first_fin = -1; first_dv = -1;
      for (int i = 0; i < tl.size(); i++) begin
         @(posedge clk); #1;
         rst_n          = (i == rst_at) ? 1'b0 : 1'b1;
         start_i        = tl[i].start;
         msg_valid_i    = tl[i].valid;
         blk_last_i     = tl[i].last;
         digest_ready_i = tl[i].dready;
`ifdef SHA2_CTRL_ABORT_EN
         abort_i        = (i == abort_at);
`endif
         @(negedge clk);
         e = tl[i].exp;
         if (i == abort_at) begin
            e[18] = 1'b0;
            e[17] = 1'b0;
         end
         tests_run++;
         if (act !== e) begin
            tests_failed++;
            if (fail_prints < 20)
               $display("[TB] FAIL %s cycle %0d: outputs %h, expected %h", name, i, act, e);
            fail_prints++;
         end
         if (iv_ld_o) n_iv++;
         if (wv_ld_o) n_wv++;
         if (final_o) n_fin++;
         if (msg_ld_o) n_ld++;
         if (hash_en_o) n_hen++;
         if (digest_valid_o) n_dv++;
         if (final_o && first_fin < 0) first_fin = i;
         if (digest_valid_o && first_dv < 0) first_dv = i;
         last_blk_seen = blk_cnt_o;
         if (i == rst_at || i == abort_at) begin
            cut = 1;
            break;
         end
      end
      if (cut) begin
         @(posedge clk); #1;
         rst_n = 1'b1; start_i = 1'b0; msg_valid_i = 1'b1; blk_last_i = 1'b0; digest_ready_i = 1'b0;
`ifdef SHA2_CTRL_ABORT_EN
         abort_i = 1'b0;
`endif
         @(negedge clk);
         tests_run++;
         if (act !== 36'h0) begin
            tests_failed++;
            $display("[TB] FAIL %s post-cut: outputs %h, expected 0", name, act);
         end
         blk_model = 0;
      end
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         rst_n = 1'b0; start_i = (k == 1); msg_valid_i = 1'b1; blk_last_i = 1'b0; digest_ready_i = 1'b1;
         @(negedge clk);
         tests_run++;
         if (act !== 36'h0 || busy80 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: outputs %h busy80 %b, expected 0", act, busy80);
         end
      end
      blk_model = 0;
   endtask

   task automatic test_single_block();
      build_message(1, 0, 0, 0, 1);
      replay("single_block", -1, -1);
      tests_run++;
      if (first_fin !== 81 || first_dv !== 82 || n_iv !== 1 || n_wv !== 1 || last_blk_seen !== 16'd1) begin
         tests_failed++;
         $display("[TB] FAIL single_block_timing: final@%0d dv@%0d iv=%0d wv=%0d blk=%0d, expected 81 82 1 1 1",
                  first_fin, first_dv, n_iv, n_wv, last_blk_seen);
      end
   endtask

   task automatic test_back_to_back();
      build_message(2, 0, 0, 0, 1);
      replay("back_to_back", -1, -1);
      tests_run++;
      if (first_dv !== 163 || n_iv !== 1 || n_wv !== 2 || n_fin !== 2 || last_blk_seen !== 16'd2) begin
         tests_failed++;
         $display("[TB] FAIL back_to_back: dv@%0d iv=%0d wv=%0d fin=%0d blk=%0d, expected 163 1 2 2 2",
                  first_dv, n_iv, n_wv, n_fin, last_blk_seen);
      end
   endtask

   task automatic test_gaps();
      build_message(2, 3, 1, 0, 1);
      replay("valid_gaps", -1, -1);
      tests_run++;
      if (n_ld !== 32 || n_hen !== 128) begin
         tests_failed++;
         $display("[TB] FAIL valid_gaps_counts: ld=%0d hen=%0d, expected 32 128", n_ld, n_hen);
      end
   endtask

   task automatic test_out_hold();
      build_message(1, 0, 10, 1, 2);
      replay("out_hold", -1, -1);
      tests_run++;
      if (n_dv !== 11 || first_dv !== 82) begin
         tests_failed++;
         $display("[TB] FAIL out_hold: dv cycles=%0d first=%0d, expected 11 82", n_dv, first_dv);
      end
   endtask

   task automatic test_reset_midrun();
      build_message(1, 0, 3, 0, 0);
      replay("reset_round30", 47, -1);
      build_message(1, 1, 0, 0, 1);
      replay("after_reset", -1, -1);
      build_message(1, 0, 5, 1, 0);
      replay("reset_in_out", 84, -1);
      build_message(1, 0, 0, 0, 1);
      replay("after_out_reset", -1, -1);
      tests_run++;
      if (last_blk_seen !== 16'd1 || n_fin !== 1) begin
         tests_failed++;
         $display("[TB] FAIL reset_recovery: blk=%0d fin=%0d, expected 1 1", last_blk_seen, n_fin);
      end
   endtask

`ifdef SHA2_CTRL_ABORT_EN
   task automatic test_abort();
      build_message(1, 0, 0, 0, 0);
      replay("abort_load", 5, -1 + 0 * 0 + 0 == 0 ? -1 : -1);
      build_message(1, 0, 0, 0, 0);
      replay("abort_load2", -1, 9);
      build_message(1, 0, 0, 0, 1);
      replay("after_abort", -1, -1);
      build_message(1, 0, 4, 1, 0);
      replay("abort_out", -1, 83);
      build_message(2, 1, 0, 0, 1);
      replay("after_abort_out", -1, -1);
      tests_run++;
      if (last_blk_seen !== 16'd2 || n_iv !== 1) begin
         tests_failed++;
         $display("[TB] FAIL abort_recovery: blk=%0d iv=%0d, expected 2 1", last_blk_seen, n_iv);
      end
   endtask
`endif

   task automatic test_random();
      for (int m = 0; m < 8; m++) begin
         int nb = $urandom_range(3, 1);
         build_message(nb, 3, $urandom_range(4, 0), 1'b0, $urandom_range(2, 1));
         replay("random_msg", -1, -1);
         tests_run++;
         if (n_ld !== 16 * nb || n_wv !== nb || n_iv !== 1 || n_fin !== nb || n_hen !== 64 * nb) begin
            tests_failed++;
            $display("[TB] FAIL random_counts msg %0d: ld=%0d wv=%0d iv=%0d fin=%0d hen=%0d for %0d blocks",
                     m, n_ld, n_wv, n_iv, n_fin, n_hen, nb);
         end
      end
   endtask

   task automatic test_rounds80();
      int hcnt = 0, rnd_err = 0, ffin = -1, fdv = -1, last_rnd = -1;
      @(posedge clk); #1;
      rst_n = 1'b0; start_i = 1'b0; msg_valid_i = 1'b0; blk_last_i = 1'b0; digest_ready_i = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk); #1;
         rst_n = 1'b1; start_i = (c == 0); msg_valid_i = (c >= 1 && c <= 16);
         blk_last_i = (c == 16); digest_ready_i = (c == 98);
         @(negedge clk);
         if (hen80) begin
            if (round80 !== 7'(hcnt)) rnd_err++;
            last_rnd = int'(round80);
            hcnt++;
         end
         if (fin80 && ffin < 0) ffin = c;
         if (dv80 && fdv < 0) fdv = c;
         if (c == 99) begin
            tests_run++;
            if (busy80 !== 1'b0) begin
               tests_failed++;
               $display("[TB] FAIL rounds80_idle: busy %b, expected 0", busy80);
            end
         end
      end
      tests_run++;
      if (hcnt !== 80 || last_rnd !== 79 || rnd_err !== 0) begin
         tests_failed++;
         $display("[TB] FAIL rounds80_steps: hash_en=%0d last round=%0d seq errors=%0d, expected 80 79 0",
                  hcnt, last_rnd, rnd_err);
      end
      tests_run++;
      if (ffin !== 97 || fdv !== 98) begin
         tests_failed++;
         $display("[TB] FAIL rounds80_timing: final@%0d dv@%0d, expected 97 98", ffin, fdv);
      end
      @(posedge clk); #1;
      rst_n = 1'b0; digest_ready_i = 1'b0; start_i = 1'b0; msg_valid_i = 1'b0;
      blk_model = 0;
   endtask

   initial begin
      test_reset();
      test_single_block();
      test_back_to_back();
      test_gaps();
      test_out_hold();
      test_reset_midrun();
`ifdef SHA2_CTRL_ABORT_EN
      test_abort();
`endif
      test_random();
      test_rounds80();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/sha2_ctrl_fsm.md
SHA2_CTRL_FSM -- requirements
Module: sha2_ctrl_fsm

Interface
REQ-001 SHALL provide parameter ROUNDS, default 64, compression rounds per block (64 = SHA-256, 80 = SHA-512; legal range 16..128).
REQ-002 SHALL provide parameter MSG_WORDS, default 16, message words accepted per block (legal range 1..16).
REQ-003 SHALL provide derived parameter RIDX_W = $clog2(ROUNDS), the width of round_o.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 start_i  in  1  begin new message; sampled in IDLE only.
REQ-007 msg_valid_i  in  1  message word present on scheduler input.
REQ-008 msg_ready_o  out  1  controller accepts word; high only in LOAD.
REQ-009 blk_last_i  in  1  current block is the message's final block; sampled on the last word accept of each block.
REQ-010 msg_ld_o  out  1  scheduler word load strobe = msg_valid_i & msg_ready_o.
REQ-011 word_idx_o  out  4  index of the word being accepted, 0..MSG_WORDS-1.
REQ-012 iv_ld_o  out  1  load H registers with IV.
REQ-013 wv_ld_o  out  1  load working variables a..h from H.
REQ-014 hash_en_o  out  1  round step enable.
REQ-015 round_o  out  RIDX_W  round index for the K ROM and Wt.
REQ-016 final_o  out  1  H += working variables strobe.
REQ-017 digest_valid_o  out  1  digest held valid.
REQ-018 digest_ready_i  in  1  consumer accepts digest.
REQ-019 busy_o  out  1  high in every state except IDLE.
REQ-020 blk_cnt_o  out  16  blocks completed in the current message, saturating at 16'hFFFF.
REQ-021 abort_i  in  1  cancel operation; present only with SHA2_CTRL_ABORT_EN.

Function
REQ-022 FSM states SHALL be IDLE, LOAD, ROUND, FINAL, OUT.
REQ-023 IDLE: start_i=1 -> LOAD next cycle; SHALL clear blk_cnt_o and set an internal first-block flag. start_i is ignored in every other state.
REQ-024 LOAD: msg_ready_o=1; word_idx_o increments by one per accepted word only; msg_valid_i low stalls the FSM indefinitely.
REQ-025 On the accept with word_idx_o=0: wv_ld_o=1, plus iv_ld_o=1 in the same cycle if the first-block flag is set; the flag clears after that accept.
REQ-026 On the accept with word_idx_o=MSG_WORDS-1: latch blk_last_i, clear word_idx_o, and go to ROUND next cycle.
REQ-027 ROUND: hash_en_o=1 for exactly ROUNDS consecutive cycles with round_o=0..ROUNDS-1; at round_o=ROUNDS-1 go to FINAL next cycle; round_o=0 outside ROUND.
REQ-028 FINAL: final_o=1 for one cycle; blk_cnt_o increments (saturating); next state is OUT if the latched last flag is set, else LOAD.
REQ-029 OUT: digest_valid_o=1 and held until digest_ready_i=1; the cycle with both high is the handshake, and the FSM goes to IDLE next cycle.
REQ-030 Latency, single block, ROUNDS=64, MSG_WORDS=16, continuous valid, start_i at cycle 0: LOAD cycles 1..16, ROUND cycles 17..80, final_o at cycle 81, digest_valid_o from cycle 82.
REQ-031 Each block after the first SHALL add exactly 16+ROUNDS+1 cycles with no idle gap when valid is continuous.
REQ-032 All outputs except blk_cnt_o and round_o are combinational from state and inputs; there are no glitch requirements.

Reset
REQ-033 rst_n=0 at a clock edge SHALL force IDLE, clear all counters and flags, and drive every output to 0, including mid-block and mid-OUT.
REQ-034 The first start_i is honoured on the first edge with rst_n=1.

Configuration
REQ-035 With SHA2_CTRL_ABORT_EN defined: abort_i=1 in any state SHALL force IDLE next cycle, clear counters and flags, and suppress final_o and digest_valid_o that cycle; abort has priority over start_i and digest_ready_i.
REQ-036 Without SHA2_CTRL_ABORT_EN: the abort_i port is absent and behaviour is identical to abort_i tied 0.

Verification
REQ-037 Single block, ROUNDS=64, start at cycle 0, 16 back-to-back words with blk_last_i=1 on word 15 -> iv_ld_o and wv_ld_o at cycle 1, final_o at cycle 81, digest_valid_o at cycle 82, blk_cnt_o=1.
REQ-038 Two blocks, blk_last_i=0 then 1 -> iv_ld_o pulses once, wv_ld_o pulses twice, final_o twice, blk_cnt_o=2, digest_valid_o at cycle 163.
REQ-039 Random msg_valid_i gaps in LOAD -> word_idx_o advances only on accepts and exactly 16 msg_ld_o pulses occur per block.
REQ-040 digest_ready_i held 0 for 10 cycles in OUT -> digest_valid_o stays 1 and start_i is ignored; IDLE is reached the cycle after ready.
REQ-041 ROUNDS=80 build -> hash_en_o high for 80 cycles with round_o ending at 79.
REQ-042 rst_n=0 at round 30, and abort_i=1 in LOAD (macro on) -> all outputs 0 and IDLE next cycle; a subsequent message hashes normally.
